// File: rtl/l2_line_burst_adapter_if.sv
// Signal bundle between the L2 line port / physical-memory burst port and the adapter.
// master: the environment (L2 cache plus physical memory); slave: the adapter itself.
interface l2_line_burst_adapter_if #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    // L2 side
    logic [31:0]       line_addr;
    logic              line_read;
    logic              line_write;
    logic [LINE_W-1:0] line_wdata;
    logic [LINE_W-1:0] line_rdata;
    logic              line_resp;

    // physical memory side
    logic [31:0]       burst_addr;
    logic              burst_read;
    logic              burst_write;
    logic [BEAT_W-1:0] burst_wdata;
    logic [BEAT_W-1:0] burst_rdata;
    logic              burst_resp;

    modport master (
        output line_addr, line_read, line_write, line_wdata,
        output burst_rdata, burst_resp,
        input  line_rdata, line_resp,
        input  burst_addr, burst_read, burst_write, burst_wdata
    );

    modport slave (
        input  line_addr, line_read, line_write, line_wdata,
        input  burst_rdata, burst_resp,
        output line_rdata, line_resp,
        output burst_addr, burst_read, burst_write, burst_wdata
    );
endinterface

// File: rtl/l2_line_burst_adapter.sv
// Line <-> burst adapter: serialises an L2 writeback line into BEATS memory beats
// and assembles BEATS refill beats into one line. Beat 0 is the least significant
// slice of the line. All outputs are decoded from registered state only.
module l2_line_burst_adapter #(
    parameter int LINE_W   = 256,
    parameter int BEAT_W   = 64,
    parameter int BEATS    = LINE_W / BEAT_W,
    parameter int OFFSET_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    l2_line_burst_adapter_if.slave bus
);
    localparam int CNT_W = $clog2(BEATS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // clears the in-line offset bits of the incoming address
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

    logic [1:0]                   state;
    logic [CNT_W-1:0]             cnt;
    logic [BEATS-1:0][BEAT_W-1:0] line_buf;
    logic [31:0]                  addr;
    logic                         last_beat;
    logic                         in_burst;

    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign in_burst  = (state == RD) || (state == WR);

    // Transaction sequencing: accept a request in IDLE, count beats on burst_resp, pulse DONE once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            line_buf <= '0;
            addr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a writeback takes priority; a simultaneous refill request is dropped
                    if (bus.line_write) begin
                        line_buf <= bus.line_wdata;
                        addr     <= bus.line_addr & ADDR_MASK;
                        cnt      <= '0;
                        state    <= WR;
                    end else if (bus.line_read) begin
                        addr  <= bus.line_addr & ADDR_MASK;
                        cnt   <= '0;
                        state <= RD;
                    end
                end
                RD: begin
                    if (bus.burst_resp) begin
                        line_buf[cnt] <= bus.burst_rdata;
                        cnt           <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                WR: begin
                    if (bus.burst_resp) begin
                        cnt <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode: requests and beat data are only driven while a burst is active.
    assign bus.burst_read  = (state == RD);
    assign bus.burst_write = (state == WR);
    assign bus.burst_addr  = in_burst ? addr : 32'd0;
    assign bus.burst_wdata = (state == WR) ? line_buf[cnt] : '0;
    assign bus.line_resp   = (state == DONE);
    assign bus.line_rdata  = line_buf;

endmodule

// File: tb/tb_l2_line_burst_adapter.sv
// Self-checking bench for l2_line_burst_adapter. The bench plays both the L2 cache and
// physical memory; expected lines, beat order, address alignment and response timing
// are derived from the strobe pattern and the stimulus values.
module tb_l2_line_burst_adapter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    l2_line_burst_adapter_if #(.LINE_W(256), .BEAT_W(64)) bus ();

    l2_line_burst_adapter #(
        .LINE_W(256), .BEAT_W(64), .BEATS(4), .OFFSET_W(5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // memory-side stimulus: beats returned on refill, strobe pattern from cycle T+1
    logic [63:0] rbeat [4];
    int          pat[$];

    // observations of one transaction, indexed by cycle T+k
    logic        obs_rd    [64];
    logic        obs_wr    [64];
    logic [31:0] obs_addr  [64];
    logic [63:0] obs_wdata [64];
    logic [255:0] obs_rdata_resp;
    logic [255:0] rdata_after;
    int          resp_cyc;
    int          resp_cnt;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit pat_at(int c);
        if (c - 1 < pat.size()) return pat[c-1] != 0;
        return 1'b1;
    endfunction

    // number of beats the memory has handed over before cycle T+k
    function automatic int strobes_before(int k);
        int n = 0;
        for (int c = 1; c < k; c++) if (n < 4 && pat_at(c)) n++;
        return n;
    endfunction

    // line_resp is expected in the cycle right after the fourth strobe
    function automatic int exp_resp();
        for (int k = 1; k < 64; k++) if (strobes_before(k) == 4) return k;
        return -1;
    endfunction

    function automatic logic [255:0] read_line();
        return {rbeat[3], rbeat[2], rbeat[1], rbeat[0]};
    endfunction

    // Issue one request and act as memory until two cycles after line_resp (bounded).
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [255:0] wl, input bit scramble);
        int nstb;
        bit s;
        bus.line_read  = rd;
        bus.line_write = wr;
        bus.line_addr  = a;
        bus.line_wdata = wl;
        @(posedge clk); #1;
        if (scramble) begin
            bus.line_addr  = $urandom;
            bus.line_wdata = rand256();
        end
        resp_cyc = -1;
        resp_cnt = 0;
        nstb     = 0;
        for (int k = 1; k < 64; k++) begin
            obs_rd[k]    = bus.burst_read;
            obs_wr[k]    = bus.burst_write;
            obs_addr[k]  = bus.burst_addr;
            obs_wdata[k] = bus.burst_wdata;
            if (bus.line_resp === 1'b1) begin
                resp_cnt++;
                if (resp_cyc < 0) begin
                    resp_cyc       = k;
                    obs_rdata_resp = bus.line_rdata;
                end
                bus.line_read  = 1'b0;
                bus.line_write = 1'b0;
            end
            if (resp_cyc > 0 && k >= resp_cyc + 2) break;
            s = (nstb < 4) && pat_at(k);
            bus.burst_resp  = s;
            bus.burst_rdata = s ? rbeat[nstb] : {$urandom, $urandom};
            if (s) nstb++;
            @(posedge clk); #1;
        end
        bus.line_read  = 1'b0;
        bus.line_write = 1'b0;
        bus.burst_resp = 1'b0;
        rdata_after    = bus.line_rdata;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.line_read   = 1'b0;
        bus.line_write  = 1'b0;
        bus.line_addr   = 32'd0;
        bus.line_wdata  = '0;
        bus.burst_rdata = '0;
        bus.burst_resp  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (bus.burst_read !== 1'b0) $display("FAIL reset_burst_read: got %b want 0", bus.burst_read); else n_pass++;
        n_chk++; if (bus.burst_write !== 1'b0) $display("FAIL reset_burst_write: got %b want 0", bus.burst_write); else n_pass++;
        n_chk++; if (bus.burst_addr !== 32'd0) $display("FAIL reset_burst_addr: got %h want 0", bus.burst_addr); else n_pass++;
        n_chk++; if (bus.burst_wdata !== 64'd0) $display("FAIL reset_burst_wdata: got %h want 0", bus.burst_wdata); else n_pass++;
        n_chk++; if (bus.line_resp !== 1'b0) $display("FAIL reset_line_resp: got %b want 0", bus.line_resp); else n_pass++;
        n_chk++; if (bus.line_rdata !== 256'd0) $display("FAIL reset_line_rdata: got %h want 0", bus.line_rdata); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_b2b();
        for (int b = 0; b < 4; b++) rbeat[b] = 64'hDEAD_BEEF_0000_0000 | 64'(b * 'h11);
        pat = '{1, 1, 1, 1};
        do_txn(1'b1, 1'b0, 32'h0000_1234, '0, 1'b0);
        n_chk++; if (resp_cyc != 5) $display("FAIL rd_latency: got %0d want 5", resp_cyc); else n_pass++;
        n_chk++; if (resp_cnt != 1) $display("FAIL rd_resp_count: got %0d want 1", resp_cnt); else n_pass++;
        n_chk++; if (obs_addr[1] !== 32'h0000_1220) $display("FAIL rd_burst_addr: got %h want 00001220", obs_addr[1]); else n_pass++;
        for (int k = 1; k < 5; k++) begin
            n_chk++; if (obs_rd[k] !== 1'b1 || obs_wr[k] !== 1'b0)
                $display("FAIL rd_request_c%0d: got rd=%b wr=%b want rd=1 wr=0", k, obs_rd[k], obs_wr[k]); else n_pass++;
        end
        n_chk++; if (obs_rd[5] !== 1'b0) $display("FAIL rd_request_done: got %b want 0", obs_rd[5]); else n_pass++;
        n_chk++; if (obs_rdata_resp !== read_line()) $display("FAIL rd_line: got %h want %h", obs_rdata_resp, read_line()); else n_pass++;
        n_chk++; if (rdata_after !== read_line()) $display("FAIL rd_line_held: got %h want %h", rdata_after, read_line()); else n_pass++;
    endtask

    task automatic test_write_bubbles();
        logic [255:0] wl;
        int er;
        wl  = rand256();
        pat = '{1, 0, 0, 1, 1, 0, 1};
        er  = exp_resp();
        do_txn(1'b0, 1'b1, 32'h8000_0047, wl, 1'b1);
        n_chk++; if (resp_cyc != 8 || er != 8) $display("FAIL wr_latency: got %0d want 8", resp_cyc); else n_pass++;
        n_chk++; if (resp_cnt != 1) $display("FAIL wr_resp_count: got %0d want 1", resp_cnt); else n_pass++;
        for (int k = 1; k < 8; k++) begin
            n_chk++; if (obs_wr[k] !== 1'b1 || obs_rd[k] !== 1'b0 || obs_addr[k] !== 32'h8000_0040 ||
                         obs_wdata[k] !== wl[strobes_before(k)*64 +: 64])
                $display("FAIL wr_beat_c%0d: got wr=%b rd=%b addr=%h data=%h want wr=1 rd=0 addr=80000040 data=%h",
                         k, obs_wr[k], obs_rd[k], obs_addr[k], obs_wdata[k], wl[strobes_before(k)*64 +: 64]);
            else n_pass++;
        end
        n_chk++; if (obs_rdata_resp !== wl) $display("FAIL wr_line_rdata: got %h want %h", obs_rdata_resp, wl); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [255:0] wl;
        wl = rand256();
        pat.delete();
        do_txn(1'b1, 1'b1, 32'hFFFF_FFE0, wl, 1'b0);
        n_chk++; if (resp_cyc != 5) $display("FAIL both_latency: got %0d want 5", resp_cyc); else n_pass++;
        for (int k = 1; k < 5; k++) begin
            n_chk++; if (obs_wr[k] !== 1'b1 || obs_rd[k] !== 1'b0 || obs_addr[k] !== 32'hFFFF_FFE0)
                $display("FAIL both_c%0d: got wr=%b rd=%b addr=%h want wr=1 rd=0 addr=ffffffe0", k, obs_wr[k], obs_rd[k], obs_addr[k]);
            else n_pass++;
        end
        for (int k = 6; k < 8; k++) begin
            n_chk++; if (obs_rd[k] !== 1'b0 || obs_wr[k] !== 1'b0)
                $display("FAIL both_no_queued_read_c%0d: got rd=%b wr=%b want 0 0", k, obs_rd[k], obs_wr[k]); else n_pass++;
        end
        n_chk++; if (obs_rdata_resp !== wl) $display("FAIL both_line: got %h want %h", obs_rdata_resp, wl); else n_pass++;
    endtask

    task automatic test_reset_mid_rd();
        int nresp;
        bus.line_read = 1'b1;
        bus.line_addr = 32'h0000_4444;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        reset         = 1'b0;
        bus.line_read = 1'b0;
        @(posedge clk); #1;
        reset          = 1'b1;
        bus.burst_resp = 1'b0;
        n_chk++; if (bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0 || bus.burst_addr !== 32'd0 ||
                     bus.burst_wdata !== 64'd0 || bus.line_resp !== 1'b0 || bus.line_rdata !== 256'd0)
            $display("FAIL midrd_reset_outputs: got rd=%b wr=%b addr=%h resp=%b rdata=%h want all 0",
                     bus.burst_read, bus.burst_write, bus.burst_addr, bus.line_resp, bus.line_rdata);
        else n_pass++;
        nresp = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.line_resp === 1'b1) nresp++;
            @(posedge clk); #1;
        end
        n_chk++; if (nresp != 0) $display("FAIL midrd_no_resp: got %0d want 0", nresp); else n_pass++;
        for (int b = 0; b < 4; b++) rbeat[b] = {$urandom, $urandom};
        pat = '{0, 1, 1, 0, 1, 1};
        do_txn(1'b1, 1'b0, 32'h0000_4444, '0, 1'b0);
        n_chk++; if (resp_cyc != 7) $display("FAIL midrd_fresh_latency: got %0d want 7", resp_cyc); else n_pass++;
        n_chk++; if (obs_rdata_resp !== read_line()) $display("FAIL midrd_fresh_line: got %h want %h", obs_rdata_resp, read_line()); else n_pass++;
    endtask

    task automatic test_stray_strobe();
        logic [255:0] prev;
        prev = bus.line_rdata;
        for (int i = 0; i < 3; i++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        n_chk++; if (bus.line_rdata !== prev) $display("FAIL stray_no_capture: got %h want %h", bus.line_rdata, prev); else n_pass++;
        for (int b = 0; b < 4; b++) rbeat[b] = {$urandom, $urandom};
        pat = '{1, 1, 1, 1};
        do_txn(1'b1, 1'b0, 32'h0ABC_DEF7, '0, 1'b0);
        n_chk++; if (resp_cyc != 5) $display("FAIL stray_latency: got %0d want 5", resp_cyc); else n_pass++;
        n_chk++; if (obs_rdata_resp !== read_line()) $display("FAIL stray_line: got %h want %h", obs_rdata_resp, read_line()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [255:0] wl;
        wl = rand256();
        pat = '{1, 1, 0, 1, 1};
        do_txn(1'b0, 1'b1, 32'h1000_0000, wl, 1'b0);
        n_chk++; if (resp_cnt != 1) $display("FAIL b2b_wr_resp_count: got %0d want 1", resp_cnt); else n_pass++;
        n_chk++; if (obs_rdata_resp !== wl) $display("FAIL b2b_wr_line: got %h want %h", obs_rdata_resp, wl); else n_pass++;
        for (int b = 0; b < 4; b++) rbeat[b] = {$urandom, $urandom};
        pat = '{1, 1, 1, 1};
        do_txn(1'b1, 1'b0, 32'h2000_003F, '0, 1'b0);
        n_chk++; if (resp_cnt != 1) $display("FAIL b2b_rd_resp_count: got %0d want 1", resp_cnt); else n_pass++;
        n_chk++; if (resp_cyc != 5) $display("FAIL b2b_rd_latency: got %0d want 5", resp_cyc); else n_pass++;
        n_chk++; if (obs_addr[1] !== 32'h2000_0020) $display("FAIL b2b_rd_addr: got %h want 20000020", obs_addr[1]); else n_pass++;
        n_chk++; if (obs_rdata_resp !== read_line()) $display("FAIL b2b_rd_line: got %h want %h", obs_rdata_resp, read_line()); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            logic        rd;
            logic        wr;
            logic [31:0] a;
            logic [255:0] wl;
            logic [255:0] expl;
            int          mode;
            int          er;
            mode = int'($urandom_range(0, 2));
            rd   = (mode != 1);
            wr   = (mode != 0);
            a    = $urandom;
            wl   = rand256();
            for (int b = 0; b < 4; b++) rbeat[b] = {$urandom, $urandom};
            pat.delete();
            for (int c = 0; c < 12; c++) pat.push_back(int'($urandom_range(0, 1)));
            er = exp_resp();
            do_txn(rd, wr, a, wl, it[0]);
            expl = wr ? wl : read_line();
            n_chk++; if (resp_cyc != er) $display("FAIL rand%0d_latency: got %0d want %0d", it, resp_cyc, er); else n_pass++;
            n_chk++; if (resp_cnt != 1) $display("FAIL rand%0d_resp_count: got %0d want 1", it, resp_cnt); else n_pass++;
            n_chk++; if (obs_rdata_resp !== expl) $display("FAIL rand%0d_line: got %h want %h", it, obs_rdata_resp, expl); else n_pass++;
            for (int k = 1; k < er; k++) begin
                n_chk++; if (obs_rd[k] !== !wr || obs_wr[k] !== wr || obs_addr[k] !== {a[31:5], 5'd0} ||
                             (wr && obs_wdata[k] !== wl[strobes_before(k)*64 +: 64]))
                    $display("FAIL rand%0d_c%0d: got rd=%b wr=%b addr=%h data=%h want rd=%b wr=%b addr=%h",
                             it, k, obs_rd[k], obs_wr[k], obs_addr[k], obs_wdata[k], !wr, wr, {a[31:5], 5'd0});
                else n_pass++;
            end
            if (er > 0) begin
                n_chk++; if (obs_rd[er] !== 1'b0 || obs_wr[er] !== 1'b0)
                    $display("FAIL rand%0d_done_req: got rd=%b wr=%b want 0 0", it, obs_rd[er], obs_wr[er]); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_b2b();
        test_write_bubbles();
        test_simultaneous();
        test_reset_mid_rd();
        test_stray_strobe();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
